// File: rtl/cp0_pkg.sv
// cp0 shared constants: register indices, field positions, exception codes.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int IM_HI  = 15;
  localparam int IM_LO  = 10;
  localparam int EXL    = 1;
  localparam int IE     = 0;
  localparam int BD     = 31;
  localparam int IP_HI  = 15;
  localparam int IP_LO  = 10;
  localparam int EXC_HI = 6;
  localparam int EXC_LO = 2;

  localparam logic [4:0] INT  = 5'd0;
  localparam logic [4:0] ADEL = 5'd4;
  localparam logic [4:0] ADES = 5'd5;
  localparam logic [4:0] RI   = 5'd10;
  localparam logic [4:0] OV   = 5'd12;

endpackage

// File: rtl/cp0_if.sv
// cp0 pipeline-side bus: mtc0/mfc0 access, victim info, IRQ lines, redirect.
interface cp0_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        We;
  logic [31:0] PC;
  logic        BD;
  logic [4:0]  ExcCode;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        Req;
  logic [31:0] ExcVec;
  logic [31:0] EPC;
  logic [31:0] DOut;

  modport master (
    output A1, A2, DIn, We, PC, BD,
    output ExcCode, HWInt, EXLClr,
    input  Req, ExcVec, EPC, DOut
  );

  modport slave (
    input  A1, A2, DIn, We, PC, BD,
    input  ExcCode, HWInt, EXLClr,
    output Req, ExcVec, EPC, DOut
  );
endinterface

// File: rtl/cp0_reqgen.sv
// Pending/priority logic: interrupts beat internal exceptions.
// CP0_EXC_EN enables internal exceptions; without it ExcCode is ignored.
module cp0_reqgen
  import cp0_pkg::*;
(
  input  logic       i_rst,
  input  logic [5:0] i_hwint,
  input  logic [5:0] i_im,
  input  logic       i_ie,
  input  logic       i_exl,
  input  logic [4:0] i_exc_code,
  output logic       o_req,
  output logic [4:0] o_code
);

  logic w_int;
  logic w_exc;

  assign w_int = (|(i_hwint & i_im)) & i_ie & ~i_exl;

`ifdef CP0_EXC_EN
  assign w_exc = (i_exc_code != INT) & ~i_exl;
`else
  logic w_unused;
  assign w_unused = ^i_exc_code;
  assign w_exc    = 1'b0;
`endif

  assign o_req = ~i_rst & (w_int | w_exc);

  always_comb begin
    o_code = INT;
    if (!w_int && w_exc) o_code = i_exc_code;
  end

endmodule

// File: rtl/cp0.sv
// Coprocessor-0: SR/Cause/EPC/PRId registers, exception entry and eret.
// Build with CP0_EXC_EN to honour internal exception codes.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID    = 32'h0000_7A7A,
  parameter logic [31:0] EXC_VEC = 32'h0000_4180
) (
  input  logic  clk,
  input  logic  rst,
  cp0_if.slave  bus
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc;
  logic [31:0] r_epc;

  logic        w_req;
  logic [4:0]  w_code;
  logic [31:0] w_victim;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

  cp0_reqgen u_reqgen (
    .i_rst      (rst),
    .i_hwint    (bus.HWInt),
    .i_im       (r_im),
    .i_ie       (r_ie),
    .i_exl      (r_exl),
    .i_exc_code (bus.ExcCode),
    .o_req      (w_req),
    .o_code     (w_code)
  );

  assign w_victim = bus.BD ? bus.PC - 32'd4 : bus.PC;

  assign w_sr    = {16'b0, r_im, 8'b0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'b0, r_ip, 3'b0, r_exc, 2'b0};

  always_comb begin
    bus.DOut = '0;
    case (bus.A1)
      REG_SR:    bus.DOut = w_sr;
      REG_CAUSE: bus.DOut = w_cause;
      REG_EPC:   bus.DOut = r_epc;
      REG_PRID:  bus.DOut = PRID;
      default:   bus.DOut = '0;
    endcase
  end

  assign bus.Req    = w_req;
  assign bus.ExcVec = EXC_VEC;
  assign bus.EPC    = r_epc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_im  <= '0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
      r_bd  <= 1'b0;
      r_ip  <= '0;
      r_exc <= '0;
      r_epc <= '0;
    end else begin
      r_ip <= bus.HWInt;
      if (w_req) begin
        // exception entry wins over mtc0 and eret
        r_exl <= 1'b1;
        r_exc <= w_code;
        r_bd  <= bus.BD;
        r_epc <= {w_victim[31:2], 2'b00};
      end else begin
        if (bus.We) begin
          case (bus.A2)
            REG_SR: begin
              r_im  <= bus.DIn[IM_HI:IM_LO];
              r_exl <= bus.DIn[EXL];
              r_ie  <= bus.DIn[IE];
            end
            REG_EPC: r_epc <= {bus.DIn[31:2], 2'b00};
            default: ;
          endcase
        end
        if (bus.EXLClr) r_exl <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed scenarios plus randomized traffic
// compared every cycle against a behavioural register model.
`timescale 1ns/100ps
module tb_cp0;

  logic clk;
  logic rst;
  cp0_if bus();

  cp0 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 0;

`ifdef CP0_EXC_EN
  localparam bit EXC_ON = 1'b1;
`else
  localparam bit EXC_ON = 1'b0;
`endif

  // behavioural state
  logic [5:0]  m_im;
  logic        m_exl;
  logic        m_ie;
  logic        m_bd;
  logic [5:0]  m_ip;
  logic [4:0]  m_exc;
  logic [31:0] m_epc;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic bit m_int();
    return ((bus.HWInt & m_im) != 0) && m_ie && !m_exl;
  endfunction

  function automatic bit m_req();
    if (rst) return 0;
    return m_int() || (EXC_ON && bus.ExcCode != 0 && !m_exl);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    case (idx)
      5'd12: return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13: return (32'(m_bd) << 31) | (32'(m_ip) << 10)
                    | (32'(m_exc) << 2);
      5'd14: return m_epc;
      5'd15: return 32'h0000_7A7A;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0;
      m_ip = 0; m_exc = 0; m_epc = 0;
    end else begin
      logic [31:0] v;
      if (m_req()) begin
        m_exc = m_int() ? 5'd0 : bus.ExcCode;
        m_exl = 1;
        m_bd  = bus.BD;
        v     = bus.BD ? bus.PC - 4 : bus.PC;
        m_epc = v & ~32'd3;
      end else begin
        if (bus.We && bus.A2 == 5'd12) begin
          v = bus.DIn;
          m_im  = v[15:10];
          m_exl = v[1];
          m_ie  = v[0];
        end
        if (bus.We && bus.A2 == 5'd14) m_epc = bus.DIn & ~32'd3;
        if (bus.EXLClr) m_exl = 0;
      end
      m_ip = bus.HWInt;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req",  32'(bus.Req), 32'(m_req()));
      chk("dout", bus.DOut, m_read(bus.A1));
      chk("epc",  bus.EPC, m_epc);
      chk("vec",  bus.ExcVec, 32'h0000_4180);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input string nm, input logic [4:0] idx,
                      input logic [31:0] exp);
    bus.A1 = idx;
    #1;
    chk(nm, bus.DOut, exp);
  endtask

  task automatic mtc0(input logic [4:0] idx, input logic [31:0] d);
    bus.We = 1; bus.A2 = idx; bus.DIn = d;
    step();
    bus.We = 0;
  endtask

  initial begin
    rst = 1;
    bus.A1 = 0; bus.A2 = 0; bus.DIn = 0; bus.We = 0;
    bus.PC = 0; bus.BD = 0; bus.ExcCode = 0;
    bus.HWInt = 0; bus.EXLClr = 0;
    step();
    chk("req_in_rst", 32'(bus.Req), 0);
    step();
    rst = 0;
    chk_en = 1;
    step();
    peek("rst_sr", 12, 0);
    peek("rst_cause", 13, 0);
    peek("rst_epc", 14, 0);
    step();
    peek("rst_prid", 15, 32'h0000_7A7A);
    chk("rst_req", 32'(bus.Req), 0);

    // timer interrupt
    mtc0(12, 32'h0000_0401);
    bus.HWInt = 6'b000001; bus.PC = 32'h0000_3010; bus.BD = 0;
    #1 chk("tmr_req", 32'(bus.Req), 1);
    step();
    chk("tmr_req_n1", 32'(bus.Req), 0);
    chk("tmr_epc", bus.EPC, 32'h0000_3010);
    peek("tmr_cause", 13, 32'h0000_0400);
    peek("tmr_sr", 12, 32'h0000_0403);

    // eret with interrupt still pending
    bus.EXLClr = 1;
    step();
    chk("eret_req", 32'(bus.Req), 1);
    // re-entry from a delay slot, eret on the same edge
    bus.PC = 32'h0000_3014; bus.BD = 1;
    step();
    bus.EXLClr = 0; bus.BD = 0;
    chk("ds_epc", bus.EPC, 32'h0000_3010);
    peek("ds_cause", 13, 32'h8000_0400);
    peek("ds_sr", 12, 32'h0000_0403);

    // masked interrupt
    mtc0(12, 32'h0000_0801);
    for (int i = 0; i < 5; i++) begin
      chk("mask_req", 32'(bus.Req), 0);
      step();
    end
    peek("mask_ip", 13, 32'h8000_0400);

    // internal exception
    mtc0(12, 32'h0);
    bus.HWInt = 0; bus.ExcCode = 5'd12; bus.PC = 32'h0000_3020;
    #1 chk("exc_req", 32'(bus.Req), EXC_ON ? 32'd1 : 32'd0);
    step();
    bus.ExcCode = 0;
    peek("exc_cause", 13, EXC_ON ? 32'h0000_0030 : 32'h8000_0000);
    peek("exc_sr", 12, EXC_ON ? 32'h0000_0002 : 32'h0);

    // randomized traffic
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] codes [4];
      codes[0] = 5'd4; codes[1] = 5'd5; codes[2] = 5'd10; codes[3] = 5'd12;
      rst = ($urandom_range(0, 149) == 0);
      bus.HWInt = ($urandom_range(0, 9) < 3) ? 6'($urandom) : 6'd0;
      bus.ExcCode = ($urandom_range(0, 9) < 2)
                    ? codes[$urandom_range(0, 3)] : 5'd0;
      bus.We = ($urandom_range(0, 9) < 2);
      bus.A2 = 5'($urandom_range(11, 16));
      bus.DIn = ($urandom_range(0, 1) == 1) ? $urandom
                : 32'($urandom) & 32'h0000_FC03;
      bus.EXLClr = !bus.We && ($urandom_range(0, 9) == 0);
      bus.PC = $urandom;
      bus.BD = 1'($urandom);
      bus.A1 = 5'($urandom_range(10, 17));
      step();
    end
    rst = 0;
    bus.We = 0; bus.EXLClr = 0;
    step();
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 interrupt and exception controller for the pipelined `mips` core. It is the CPU-side receiver of the 6-bit `HWInt` vector driven by the system bridge from timer and device IRQ lines. It masks and prioritises pending requests and records the victim PC and cause. It redirects the pipeline to the handler and services `mtc0`/`mfc0`/`eret`.

## Interface
Parameters:
- `PRID`, 32'h0000_7A7A: read-only processor ID value.
- `EXC_VEC`, 32'h0000_4180: handler entry address presented on `ExcVec`.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `A1`  in  5  `mfc0` read register index
- `A2`  in  5  `mtc0` write register index
- `DIn`  in  32  `mtc0` write data
- `We`  in  1  `mtc0` write enable (M stage)
- `PC`  in  32  PC of the M-stage instruction (victim)
- `BD`  in  1  victim is in a branch delay slot
- `ExcCode`  in  5  internal exception code from pipeline, 0 = none
- `HWInt`  in  6  hardware interrupt lines from bridge, level-sensitive
- `EXLClr`  in  1  `eret` in M stage
- `Req`  out  1  take exception/interrupt this cycle (flush, redirect)
- `ExcVec`  out  32  constant `EXC_VEC`
- `EPC`  out  32  current EPC register, for `eret` target
- `DOut`  out  32  `mfc0` read data

## Operation
- Registers: SR (12): IM[15:10], EXL[1], IE[0], other bits read 0. Cause (13): BD[31], IP[15:10], ExcCode[6:2], other bits 0. EPC (14): full 32 bits. PRId (15): `PRID`. Other indices read 0.
- `DOut` = register at `A1`, combinational. Writes to Cause and PRId are ignored. An SR write stores only IM/EXL/IE. An EPC write stores `DIn` with [1:0] forced to 0.
- `IntPend` = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
- `ExcPend` = (ExcCode != 0) & ~SR.EXL.
- `Req` = IntPend | ExcPend, combinational.
- Priority: interrupt over internal exception. The recorded code is 0 for an interrupt, otherwise `ExcCode`.
- On an edge with `Req`=1:
  - SR.EXL←1.
  - Cause.ExcCode←selected code; Cause.BD←`BD`.
  - EPC←(`BD` ? `PC`−4 : `PC`) with [1:0]=0.
  - A concurrent `mtc0` (`We`) is discarded.
- `EXLClr` clears SR.EXL on the edge. `Req` has priority: if both occur, EXL stays 1.
- Cause.IP←`HWInt` on every edge regardless of mask, EXL, or `Req`.
- `rst` zeroes SR, Cause and EPC. All outputs then read 0, except `ExcVec` and PRId reads.

## Timing
- `Req` and `DOut` are same-cycle combinational. Register updates land on the next rising edge.
- Exception entry takes 1 cycle. In cycle N+1, SR.EXL=1 and `Req`=0, even if `HWInt` is still asserted.
- `eret` at edge N: EXL=0 from N+1. A still-pending masked-in interrupt raises `Req` in N+1.
- `mtc0` SR enabling IE at edge N: an interrupt can fire in N+1, not N.
- `HWInt` change is visible in `Req` the same cycle and in Cause.IP one cycle later.
- `rst` asserted mid-handler (EXL=1) returns all state to reset values on that edge. `Req` is forced 0 while `rst`=1.

## Configuration
- `CP0_EXC_EN` defined: internal exceptions are honoured as described, and `ExcCode` is used.
- `CP0_EXC_EN` undefined:
  - `ExcCode` is ignored and `ExcPend`≡0. Only interrupts set `Req`, and Cause.ExcCode is always written 0.
  - The port remains present, unconnected internally.

## Structure
- Package `cp0_pkg` holds:
  - register indices SR=12, CAUSE=13, EPC=14, PRID=15;
  - bit positions IM_HI/IM_LO, EXL, IE, BD, IP_HI/IP_LO, EXC_HI/EXC_LO;
  - ExcCode constants INT=0, ADEL=4, ADES=5, RI=10, OV=12.
- One sub-module, `cp0_reqgen`: combinational pending/priority logic producing `Req` and the selected code. The register file and write muxing stay in `cp0`.

## Test plan
- Reset then read: `rst`=1 one cycle; A1=12/13/14/15 → DOut 0/0/0/32'h0000_7A7A, `Req`=0.
- Timer interrupt: mtc0 SR=32'h0000_0401 (IM[10], IE); HWInt=6'b000001, PC=32'h0000_3010, BD=0 → `Req`=1 that cycle. Next cycle: EPC=32'h0000_3010, Cause=32'h0000_0400, SR.EXL=1, `Req`=0.
- Delay slot: same setup with BD=1, PC=32'h0000_3014 → EPC=32'h0000_3010, Cause[31]=1.
- Masking: SR=32'h0000_0801 (IM[11] only), HWInt=6'b000001 for 5 cycles → `Req`=0 throughout, Cause.IP=6'b000001.
- eret/re-entry: in handler with HWInt held at 1, assert EXLClr one cycle → EXL=0 next cycle and `Req`=1. With EXLClr and `Req` on the same edge → EXL stays 1.
- Internal exception (`CP0_EXC_EN`): SR=0, ExcCode=12 → `Req`=1, Cause.ExcCode=12. With the macro undefined → `Req`=0, no state change.
